sync_cmd_loader: RTL and testbench

SYNC_CMD_LOADER -- requirements
Module: sync_cmd_loader

---
 rtl/sync_cmd_loader.sv | 148 ++++++++++++++
 tb/tb_sync_cmd_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_cmd_loader.sv
// Byte-stream command loader: header-framed 43-byte payload with additive checksum,
// decoded into DDS/burst parameters and handed over with a WR_DATA strobe.
module sync_cmd_loader #(
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         TIMEOUT = 48000,
  parameter int         WR_LEN  = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  DATA_IN,
  input  logic        DATA_VALID,
  output logic [47:0] MEM_DDS_freq,
  output logic [47:0] MEM_DDS_delta_freq,
  output logic [31:0] MEM_DDS_delta_rate,
  output logic [63:0] MEM_TIME_START,
  output logic [15:0] MEM_N_impuls,
  output logic [1:0]  MEM_TYPE_impulse,
  output logic [31:0] MEM_Interval_Ti,
  output logic [31:0] MEM_Interval_Tp,
  output logic [31:0] MEM_Tblank1,
  output logic [31:0] MEM_Tblank2,
  output logic        WR_DATA,
  output logic        PKT_OK,
  output logic        PKT_ERR,
  output logic [7:0]  ERR_CNT
);

  localparam int             TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]  TMO_ONE  = TW'(1);
  localparam logic [3:0]     WR_N     = 4'(WR_LEN);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK, S_WRITE} state_t;

  state_t         state_q, state_d;
  logic [343:0]   shadow_q, shadow_d;
  logic [337:0]   mem_q, mem_d;
  logic [5:0]     idx_q, idx_d;
  logic [7:0]     sum_q, sum_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [3:0]     wcnt_q, wcnt_d;
  logic           wr_q, wr_d, ok_q, ok_d, err_q, err_d;
  logic [7:0]     ecnt_q, ecnt_d;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    mem_d    = mem_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    tmo_d    = tmo_q;
    wcnt_d   = wcnt_q;
    wr_d     = 1'b0;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (DATA_VALID && DATA_IN == HEADER) begin
          state_d = S_PAYLOAD;
          idx_d   = '0;
          sum_d   = '0;
          tmo_d   = '0;
        end
      end
      S_PAYLOAD, S_CHECK: begin
        if (DATA_VALID) begin
          tmo_d = '0;
          if (state_q == S_PAYLOAD) begin
            // HEADER-valued bytes are plain data here; no mid-packet resync
            shadow_d = {shadow_q[335:0], DATA_IN};
            sum_d    = sum_q + DATA_IN;
            idx_d    = idx_q + 6'd1;
            if (idx_q == 6'd42) state_d = S_CHECK;
          end else if (DATA_IN == sum_q) begin
            state_d = S_WRITE;
            ok_d    = 1'b1;
            wcnt_d  = '0;
            // type byte keeps only bits [1:0]
            mem_d   = {shadow_q[343:136], shadow_q[129:128], shadow_q[127:0]};
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      S_WRITE: begin
        // first WRITE cycle carries PKT_OK, then WR_LEN cycles of strobe
        if (wcnt_q == WR_N) begin
          state_d = S_IDLE;
        end else begin
          wr_d   = 1'b1;
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ecnt_d = (err_d && ecnt_q != 8'hFF) ? ecnt_q + 8'd1 : ecnt_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      mem_q    <= '0;
      idx_q    <= '0;
      sum_q    <= '0;
      tmo_q    <= '0;
      wcnt_q   <= '0;
      wr_q     <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      ecnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      mem_q    <= mem_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      tmo_q    <= tmo_d;
      wcnt_q   <= wcnt_d;
      wr_q     <= wr_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      ecnt_q   <= ecnt_d;
    end
  end

  assign MEM_DDS_freq       = mem_q[337:290];
  assign MEM_DDS_delta_freq = mem_q[289:242];
  assign MEM_DDS_delta_rate = mem_q[241:210];
  assign MEM_TIME_START     = mem_q[209:146];
  assign MEM_N_impuls       = mem_q[145:130];
  assign MEM_TYPE_impulse   = mem_q[129:128];
  assign MEM_Interval_Ti    = mem_q[127:96];
  assign MEM_Interval_Tp    = mem_q[95:64];
  assign MEM_Tblank1        = mem_q[63:32];
  assign MEM_Tblank2        = mem_q[31:0];
  assign WR_DATA            = wr_q;
  assign PKT_OK             = ok_q;
  assign PKT_ERR            = err_q;
  assign ERR_CNT            = ecnt_q;

endmodule

// File: tb/tb_sync_cmd_loader.sv
// Directed bench for sync_cmd_loader: packet vector table plus timeout/reset/saturation sequences.
module tb_sync_cmd_loader;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  DATA_IN = 8'h00;
  logic        DATA_VALID = 1'b0;
  logic [47:0] f_o, df_o;
  logic [31:0] dr_o, ti_o, tp_o, tb1_o, tb2_o;
  logic [63:0] ts_o;
  logic [15:0] n_o;
  logic [1:0]  ty_o;
  logic        WR_DATA, PKT_OK, PKT_ERR;
  logic [7:0]  ERR_CNT;

  sync_cmd_loader dut (
    .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID),
    .MEM_DDS_freq(f_o), .MEM_DDS_delta_freq(df_o), .MEM_DDS_delta_rate(dr_o),
    .MEM_TIME_START(ts_o), .MEM_N_impuls(n_o), .MEM_TYPE_impulse(ty_o),
    .MEM_Interval_Ti(ti_o), .MEM_Interval_Tp(tp_o), .MEM_Tblank1(tb1_o), .MEM_Tblank2(tb2_o),
    .WR_DATA(WR_DATA), .PKT_OK(PKT_OK), .PKT_ERR(PKT_ERR), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  logic [337:0] mem_cat;
  assign mem_cat = {f_o, df_o, dr_o, ts_o, n_o, ty_o, ti_o, tp_o, tb1_o, tb2_o};

  typedef struct {
    logic [47:0] f, df;
    logic [31:0] dr;
    logic [63:0] ts;
    logic [15:0] n;
    logic [7:0]  ty;
    logic [31:0] ti, tp, tb1, tb2;
    logic [7:0]  cadd;
    bit          garb;
    bit          ok;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  int n_ok = 0, n_err = 0, n_wr = 0;
  int both_viol = 0, stable_viol = 0, order_viol = 0;
  logic [337:0] snap = '0;
  logic prev_ok = 1'b0;

  always @(negedge CLK) begin
    n_ok  <= n_ok + int'(PKT_OK);
    n_err <= n_err + int'(PKT_ERR);
    n_wr  <= n_wr + int'(WR_DATA);
    if (PKT_OK && PKT_ERR) both_viol <= both_viol + 1;
    if (PKT_OK) snap <= mem_cat;
    if (WR_DATA && mem_cat != snap) stable_viol <= stable_viol + 1;
    prev_ok <= PKT_OK;
    if (prev_ok && !WR_DATA && !RESET) order_viol <= order_viol + 1;
  end

  task automatic chk(input string name, input logic [337:0] act, input logic [337:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [47:0] f, df, input logic [31:0] dr, input logic [63:0] ts,
                              input logic [15:0] n, input logic [7:0] ty,
                              input logic [31:0] ti, tp, tb1, tb2,
                              input logic [7:0] cadd, input bit garb, input bit ok);
    vec_t v;
    v.f = f; v.df = df; v.dr = dr; v.ts = ts; v.n = n; v.ty = ty;
    v.ti = ti; v.tp = tp; v.tb1 = tb1; v.tb2 = tb2;
    v.cadd = cadd; v.garb = garb; v.ok = ok;
    return v;
  endfunction

  function automatic logic [337:0] mem_of(input vec_t v);
    return {v.f, v.df, v.dr, v.ts, v.n, v.ty[1:0], v.ti, v.tp, v.tb1, v.tb2};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    DATA_IN = b;
    DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
  endtask

  task automatic send_pkt(input vec_t v, input int tail);
    logic [343:0] pl;
    logic [7:0] s;
    pl = {v.f, v.df, v.dr, v.ts, v.n, v.ty, v.ti, v.tp, v.tb1, v.tb2};
    s = 8'h00;
    if (v.garb) begin
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    end
    send_byte(8'hA5);
    for (int i = 0; i < 43; i++) begin
      s = s + pl[343 - 8*i -: 8];
      send_byte(pl[343 - 8*i -: 8]);
    end
    send_byte(s + v.cadd);
    repeat (tail) begin @(posedge CLK); #1; end
  endtask

  vec_t vt[7];
  vec_t v0;
  logic [337:0] exp_mem;
  logic [7:0] exp_ecnt;
  int ok0, err0, wr0;

  initial begin
    v0 = mk(48'h001000000000, 48'h100000, 32'h100, 64'h12C0, 16'd2, 8'h01,
            32'h1800, 32'h1800, 32'h180, 32'h180, 8'h00, 1'b0, 1'b1);
    vt[0] = v0;
    vt[1] = v0; vt[1].cadd = 8'h01; vt[1].ok = 1'b0;
    vt[2] = mk(48'hA5A5A5A5A5A5, 48'h0000A5000000, 32'hA5A50001, 64'hDEADBEEFA5A5A5A5, 16'hA5A5, 8'hA6,
               32'h01234567, 32'h89ABCDEF, 32'hA5000000, 32'h000000A5, 8'h00, 1'b1, 1'b1);
    vt[3] = mk('1, '1, '1, '1, '1, 8'hFF, '1, '1, '1, '1, 8'h00, 1'b0, 1'b1);
    vt[4] = mk(48'h123456789ABC, 48'h0F0F0F0F0F0F, 32'hCAFEF00D, 64'h0102030405060708, 16'h1234, 8'h03,
               32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 8'h80, 1'b0, 1'b0);
    vt[5] = mk('0, '0, '0, '0, '0, 8'h00, '0, '0, '0, '0, 8'h00, 1'b0, 1'b1);
    vt[6] = vt[4]; vt[6].cadd = 8'hFF; vt[6].garb = 1'b1; vt[6].ok = 1'b0;

    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("reset_mem", mem_cat, '0);
    chk("reset_wr", 338'(WR_DATA), 338'(0));
    chk("reset_ok", 338'(PKT_OK), 338'(0));
    chk("reset_err", 338'(PKT_ERR), 338'(0));
    chk("reset_ecnt", 338'(ERR_CNT), 338'(0));

    exp_mem = '0;
    exp_ecnt = 8'd0;
    @(posedge CLK); #1;
    for (int k = 0; k < 7; k++) begin
      ok0 = n_ok; err0 = n_err; wr0 = n_wr;
      send_pkt(vt[k], 10);
      @(negedge CLK);
      if (vt[k].ok) exp_mem = mem_of(vt[k]); else exp_ecnt = exp_ecnt + 8'd1;
      chk($sformatf("v%0d_ok_pulses", k), 338'(n_ok - ok0), 338'(vt[k].ok ? 1 : 0));
      chk($sformatf("v%0d_err_pulses", k), 338'(n_err - err0), 338'(vt[k].ok ? 0 : 1));
      chk($sformatf("v%0d_wr_cycles", k), 338'(n_wr - wr0), 338'(vt[k].ok ? 4 : 0));
      chk($sformatf("v%0d_mem", k), mem_cat, exp_mem);
      chk($sformatf("v%0d_ecnt", k), 338'(ERR_CNT), 338'(exp_ecnt));
      @(posedge CLK); #1;
    end

    // timeout: header + 10 bytes, then silence
    err0 = n_err;
    send_byte(8'hA5);
    for (int i = 0; i < 10; i++) send_byte(8'(i + 3));
    repeat (47990) @(posedge CLK);
    @(negedge CLK);
    chk("tmo_early_err", 338'(n_err - err0), 338'(0));
    repeat (15) @(posedge CLK);
    @(negedge CLK);
    exp_ecnt = exp_ecnt + 8'd1;
    chk("tmo_err", 338'(n_err - err0), 338'(1));
    chk("tmo_ecnt", 338'(ERR_CNT), 338'(exp_ecnt));
    chk("tmo_mem_kept", mem_cat, exp_mem);
    @(posedge CLK); #1;
    ok0 = n_ok;
    send_pkt(v0, 10);
    @(negedge CLK);
    chk("tmo_next_ok", 338'(n_ok - ok0), 338'(1));
    chk("tmo_next_mem", mem_cat, mem_of(v0));

    // reset at payload byte 20
    @(posedge CLK); #1;
    err0 = n_err;
    send_byte(8'hA5);
    for (int i = 0; i < 20; i++) send_byte(8'hA5 ^ 8'(i));
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_mid_mem", mem_cat, '0);
    chk("rst_mid_ecnt", 338'(ERR_CNT), 338'(0));
    chk("rst_mid_wr", 338'(WR_DATA), 338'(0));
    chk("rst_mid_no_err", 338'(n_err - err0), 338'(0));
    @(posedge CLK); #1;
    ok0 = n_ok; wr0 = n_wr;
    send_pkt(vt[2], 10);
    @(negedge CLK);
    chk("rst_next_ok", 338'(n_ok - ok0), 338'(1));
    chk("rst_next_wr", 338'(n_wr - wr0), 338'(4));
    chk("rst_next_mem", mem_cat, mem_of(vt[2]));

    // reset while the write strobe is active
    @(posedge CLK); #1;
    err0 = n_err;
    send_pkt(v0, 0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rst_wr_drop", 338'(WR_DATA), 338'(0));
    chk("rst_wr_mem", mem_cat, '0);
    chk("rst_wr_no_err", 338'(n_err - err0), 338'(0));
    #1 RESET = 1'b0;
    @(posedge CLK); #1;

    // saturation of the error counter
    wr0 = n_wr;
    for (int k = 0; k < 260; k++) send_pkt(vt[1], 2);
    @(negedge CLK);
    chk("sat_ecnt", 338'(ERR_CNT), 338'(255));
    chk("sat_mem", mem_cat, '0);
    chk("sat_no_wr", 338'(n_wr - wr0), 338'(0));

    chk("ok_err_exclusive", 338'(both_viol), 338'(0));
    chk("mem_stable_during_wr", 338'(stable_viol), 338'(0));
    chk("wr_follows_ok", 338'(order_viol), 338'(0));

    $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
    $finish;
  end

endmodule
